ysyx_22040127_ifu: RTL

YSYX_22040127_IFU -- requirements
Module: ysyx_22040127_ifu

---
 rtl/ysyx_22040127_ifu_pkg.sv | 22 ++
 rtl/ysyx_22040127_pc_reg.sv | 30 +++
 rtl/ysyx_22040127_ifu.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ysyx_22040127_ifu_pkg.sv
// Shared fetch-unit types and constants; the decoder imports the width constants too.
package ysyx_22040127_ifu_pkg;

  localparam int XLEN   = 64;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 64'd4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } ifuState_t;

  function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] pc);
    return pc & ~64'd3;
  endfunction

endpackage

// File: rtl/ysyx_22040127_pc_reg.sv
// Program counter: async reset to RESET_PC, +4 step, word-aligned redirect load.
module ysyx_22040127_pc_reg
  import ysyx_22040127_ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_inc,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_loadPc,
  output logic [XLEN-1:0] o_pc
);

  logic [XLEN-1:0] r_pc;

  // A load always wins over the increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= alignPc(RESET_PC);
    end else if (i_load) begin
      r_pc <= alignPc(i_loadPc);
    end else if (i_inc) begin
      r_pc <= r_pc + PC_STEP;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/ysyx_22040127_ifu.sv
// Instruction fetch unit: single-outstanding request/grant/rvalid fetch with a one-entry decode buffer.
module ysyx_22040127_ifu
  import ysyx_22040127_ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_imem_req,
  output logic [XLEN-1:0]   o_imem_addr,
  input  logic              i_imem_gnt,
  input  logic              i_imem_rvalid,
  input  logic [INST_W-1:0] i_imem_rdata,
  input  logic              i_redirect,
  input  logic [XLEN-1:0]   i_redirect_pc,
  input  logic              i_halt,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic [INST_W-1:0] o_instruction,
  output logic [XLEN-1:0]   o_inst_pc
);

  ifuState_t         r_state;
  ifuState_t         w_nextState;
  logic [INST_W-1:0] r_instBuf;
  logic [XLEN-1:0]   r_instPc;
  logic              r_pendValid;
  logic [XLEN-1:0]   r_pendPc;

  logic              w_pcInc;
  logic              w_pcLoad;
  logic [XLEN-1:0]   w_pcLoadVal;
  logic              w_capture;
  logic              w_pendSet;
  logic              w_pendClr;
  logic [XLEN-1:0]   w_pc;

  ysyx_22040127_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pcReg (
    .clk      (clk),
    .rst      (rst),
    .i_inc    (w_pcInc),
    .i_load   (w_pcLoad),
    .i_loadPc (w_pcLoadVal),
    .o_pc     (w_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A redirect seen while the request is still ungranted is parked here so the address stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pendValid <= 1'b0;
      r_pendPc    <= '0;
    end else if (w_pendSet) begin
      r_pendValid <= 1'b1;
      r_pendPc    <= i_redirect_pc;
    end else if (w_pendClr) begin
      r_pendValid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instBuf <= '0;
      r_instPc  <= '0;
    end else if (w_capture) begin
      r_instBuf <= i_imem_rdata;
      r_instPc  <= w_pc;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_pcInc     = 1'b0;
    w_pcLoad    = 1'b0;
    w_pcLoadVal = i_redirect_pc;
    w_capture   = 1'b0;
    w_pendSet   = 1'b0;
    w_pendClr   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_pcLoad    = i_redirect;
        w_nextState = i_halt ? S_IDLE : S_REQ;
      end

      S_REQ: begin
        if (i_imem_gnt) begin
          w_nextState = S_WAIT;
          if (i_redirect || r_pendValid) begin
            w_pcLoad    = 1'b1;
            w_pcLoadVal = i_redirect ? i_redirect_pc : r_pendPc;
            w_pendClr   = 1'b1;
            w_nextState = S_DRAIN;
          end
        end else if (i_redirect) begin
          w_pendSet = 1'b1;
        end
      end

      S_WAIT: begin
        if (i_redirect) begin
          w_pcLoad    = 1'b1;
          w_nextState = i_imem_rvalid ? S_REQ : S_DRAIN;
        end else if (i_imem_rvalid) begin
          w_capture   = 1'b1;
          w_pcInc     = 1'b1;
          w_nextState = S_HOLD;
        end
      end

      // Redirect with or without inst_ready ends the hold the same way.
      S_HOLD: begin
        if (i_redirect || i_inst_ready) begin
          w_pcLoad    = i_redirect;
          w_nextState = i_halt ? S_IDLE : S_REQ;
        end
      end

      S_DRAIN: begin
        w_pcLoad = i_redirect;
        if (i_imem_rvalid) begin
          w_nextState = S_REQ;
        end
      end

      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  assign o_imem_req    = (r_state == S_REQ);
  assign o_imem_addr   = w_pc;
  assign o_inst_valid  = (r_state == S_HOLD);
  assign o_instruction = r_instBuf;
  assign o_inst_pc     = r_instPc;

endmodule
